// File: rtl/bank_scheduler.sv
// Single-bank command scheduler: takes read/write requests and sequences the
// ACT / PR / RD / WR commands for one DRAM bank. It enforces the tRCD, tRP and
// tRAS timing limits. Bursts wrap their column within an aligned BL block.
// A halt freezes all state and timing, and masks the command outputs.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   halt       freeze request; masks commands/done in the same cycle
//   req_valid  request present
//   req_ready  request accepted when high with req_valid (combinational)
//   req_write  1 = write, 0 = read
//   req_row    target row
//   req_col    burst start column
//   commands   one-hot bank command bus (ACT=18, PR=7, RD=5, WR=1)
//   row        row to the bank
//   column     column to the bank
//   busy       high whenever the state is not IDLE or OPEN
//   done       one-cycle pulse on the last burst cycle
module bank_scheduler #(
  parameter int unsigned ROWS = 131072,
  parameter int unsigned COLS = 1024,
  parameter int unsigned BL   = 8,
  parameter int unsigned tRCD = 3,
  parameter int unsigned tRP  = 3,
  parameter int unsigned tRAS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    halt,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [$clog2(ROWS)-1:0] req_row,
  input  logic [$clog2(COLS)-1:0] req_col,
  output logic [18:0]             commands,
  output logic [$clog2(ROWS)-1:0] row,
  output logic [$clog2(COLS)-1:0] column,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned RW   = $clog2(ROWS);
  localparam int unsigned CW   = $clog2(COLS);
  localparam int unsigned BW   = $clog2(BL);
  localparam int unsigned TMAX = (tRCD > tRP) ? tRCD : tRP;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned RASW = $clog2(tRAS + 1);

  localparam logic [18:0] CMD_ACT = 19'h40000;
  localparam logic [18:0] CMD_PR  = 19'h00080;
  localparam logic [18:0] CMD_RD  = 19'h00020;
  localparam logic [18:0] CMD_WR  = 19'h00002;

  typedef enum logic [2:0] {
    S_IDLE, S_ACT_WAIT, S_OPEN, S_PRE_WAIT, S_BURST
  } state_t;

  state_t          r_state;
  logic [18:0]     r_cmd;
  logic [RW-1:0]   r_row;
  logic [CW-1:0]   r_column;
  logic            r_done;
  logic            r_req_write;
  logic [RW-1:0]   r_req_row;
  logic [CW-1:0]   r_req_col;
  logic [RW-1:0]   r_open_row;
  logic [BW-1:0]   r_idx;
  logic [TW-1:0]   r_tcnt;
  logic [RASW-1:0] r_ras;
  logic            r_pr_issued;

  logic            w_accept;
  logic [RASW-1:0] w_ras_next;
  logic [BW-1:0]   w_next_idx;
  logic [CW-1:0]   w_next_col;
  logic [18:0]     w_burst_cmd;

  assign req_ready   = (r_state == S_IDLE || r_state == S_OPEN) && !halt && !reset;
  assign w_accept    = req_valid && req_ready;
  // r_ras = cycles since the last ACT, saturating at tRAS; this is its next value
  assign w_ras_next  = (r_ras == RASW'(tRAS)) ? r_ras : r_ras + RASW'(1);
  assign w_next_idx  = r_idx + BW'(1);
  // Low column bits wrap inside the aligned BL block
  assign w_next_col  = {r_req_col[CW-1:BW], BW'(r_req_col[BW-1:0] + w_next_idx)};
  assign w_burst_cmd = r_req_write ? CMD_WR : CMD_RD;

  // Halt masks the pending command in the same cycle; it is replayed afterwards
  assign commands = halt ? 19'h0 : r_cmd;
  assign done     = r_done && !halt;
  assign busy     = !(r_state == S_IDLE || r_state == S_OPEN);
  assign row      = r_row;
  assign column   = r_column;

  // Scheduler FSM; every register freezes while halt is high
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cmd       <= '0;
      r_row       <= '0;
      r_column    <= '0;
      r_done      <= 1'b0;
      r_req_write <= 1'b0;
      r_req_row   <= '0;
      r_req_col   <= '0;
      r_open_row  <= '0;
      r_idx       <= '0;
      r_tcnt      <= '0;
      r_ras       <= '0;
      r_pr_issued <= 1'b0;
    end else if (!halt) begin
      r_cmd  <= '0;
      r_done <= 1'b0;
      r_ras  <= w_ras_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_req_write <= req_write;
            r_req_row   <= req_row;
            r_req_col   <= req_col;
            r_cmd       <= CMD_ACT;
            r_row       <= req_row;
            r_ras       <= '0;
            r_tcnt      <= '0;
            r_state     <= S_ACT_WAIT;
          end
        end
        S_ACT_WAIT: begin
          if (r_tcnt == TW'(tRCD - 1)) begin
            r_cmd      <= w_burst_cmd;
            r_row      <= r_req_row;
            r_column   <= r_req_col;
            r_open_row <= r_req_row;
            r_idx      <= '0;
            r_state    <= S_BURST;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        S_OPEN: begin
          if (w_accept) begin
            r_req_write <= req_write;
            r_req_row   <= req_row;
            r_req_col   <= req_col;
            if (req_row == r_open_row) begin
              r_cmd    <= req_write ? CMD_WR : CMD_RD;
              r_row    <= req_row;
              r_column <= req_col;
              r_idx    <= '0;
              r_state  <= S_BURST;
            end else begin
              r_state     <= S_PRE_WAIT;
              r_pr_issued <= 1'b0;
              if (w_ras_next == RASW'(tRAS)) begin
                r_cmd       <= CMD_PR;
                r_pr_issued <= 1'b1;
                r_tcnt      <= '0;
              end
            end
          end
        end
        S_PRE_WAIT: begin
          // First wait out tRAS before PR, then tRP before the new ACT
          if (!r_pr_issued) begin
            if (w_ras_next == RASW'(tRAS)) begin
              r_cmd       <= CMD_PR;
              r_pr_issued <= 1'b1;
              r_tcnt      <= '0;
            end
          end else if (r_tcnt == TW'(tRP - 1)) begin
            r_cmd   <= CMD_ACT;
            r_row   <= r_req_row;
            r_ras   <= '0;
            r_tcnt  <= '0;
            r_state <= S_ACT_WAIT;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        S_BURST: begin
          if (r_idx == BW'(BL - 1)) begin
            r_state <= S_OPEN;
          end else begin
            r_cmd    <= w_burst_cmd;
            r_idx    <= w_next_idx;
            r_column <= w_next_col;
            r_done   <= (w_next_idx == BW'(BL - 1));
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
